bullet_controller: RTL and testbench

Per-player projectile engine feeding the color mapper: launches one bullet from the shooter's position on a fire request and advances it once per video frame. It retires the bullet at the playfield edge or on contact with the opposing ball. Outputs BulletX/BulletY/bullet_on consumed directly by the color mapper; hit/hit_count go to game/score logic. One instance per player, differing only in DIR.

---
 rtl/bullet_controller.sv | 169 ++++++++++++++++
 tb/tb_bullet_controller.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/bullet_controller.sv
// Per-player projectile engine: launches from the shooter, advances once per frame tick, retires on edge or contact.
// Optional refire lockout enabled by defining BULLET_COOLDOWN_EN.
//
// state    | meaning
// IDLE     | no bullet; waiting for an armed fire on a tick
// FLY      | bullet visible, moves STEP pixels per tick
// COOLDOWN | post-retire lockout (BULLET_COOLDOWN_EN only)
module bullet_controller #(
  parameter logic DIR           = 1'b1,
  parameter int   STEP          = 4,
  parameter int   LAUNCH_OFFSET = 8,
  parameter int   X_MIN         = 0,
  parameter int   X_MAX         = 639,
  parameter int   HIT_RADIUS    = 8
`ifdef BULLET_COOLDOWN_EN
  ,
  parameter int   COOLDOWN_FRAMES = 30
`endif
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic       fire,
  input  logic [9:0] ShooterX,
  input  logic [9:0] ShooterY,
  input  logic [9:0] TargetX,
  input  logic [9:0] TargetY,
  output logic [9:0] BulletX,
  output logic [9:0] BulletY,
  output logic [9:0] bullet_on,
  output logic       hit,
  output logic [3:0] hit_count
);

  typedef enum logic [1:0] {IDLE, FLY, COOLDOWN} state_t;

  localparam logic signed [10:0] STEP_S  = 11'(STEP);
  localparam logic signed [10:0] OFF_S   = 11'(LAUNCH_OFFSET);
  localparam logic signed [10:0] X_MIN_S = 11'(X_MIN);
  localparam logic signed [10:0] X_MAX_S = 11'(X_MAX);
  localparam logic signed [10:0] HIT_S   = 11'(HIT_RADIUS);

  state_t state, state_n;
  logic   sync_s1, sync_s2, tick;
  logic   armed, armed_n, on_q, on_n, hit_n;
  logic [9:0] bx_n, by_n;
  logic [3:0] hc_n;
`ifdef BULLET_COOLDOWN_EN
  logic [7:0] cnt, cnt_n;
`endif

  logic signed [10:0] shooter_s, raw_launch, launch_x, bullet_s, next_x;
  logic signed [10:0] dx, dy, adx, ady;
  logic               contact, off_edge;

  assign tick      = sync_s1 & ~sync_s2;
  assign bullet_on = {9'd0, on_q};

  // All position math in 11-bit signed so launch offsets and steps never wrap.
  always_comb begin
    shooter_s  = signed'({1'b0, ShooterX});
    bullet_s   = signed'({1'b0, BulletX});
    raw_launch = DIR ? shooter_s + OFF_S : shooter_s - OFF_S;
    if (raw_launch < X_MIN_S)
      launch_x = X_MIN_S;
    else if (raw_launch > X_MAX_S)
      launch_x = X_MAX_S;
    else
      launch_x = raw_launch;
    next_x   = DIR ? bullet_s + STEP_S : bullet_s - STEP_S;
    off_edge = (next_x < X_MIN_S) || (next_x > X_MAX_S);
    dx       = bullet_s - signed'({1'b0, TargetX});
    dy       = signed'({1'b0, BulletY}) - signed'({1'b0, TargetY});
    adx      = dx[10] ? -dx : dx;
    ady      = dy[10] ? -dy : dy;
    contact  = (adx <= HIT_S) && (ady <= HIT_S);
  end

  always_comb begin
    state_n = state;
    armed_n = armed;
    bx_n    = BulletX;
    by_n    = BulletY;
    on_n    = on_q;
    hit_n   = 1'b0;
    hc_n    = hit_count;
`ifdef BULLET_COOLDOWN_EN
    cnt_n   = cnt;
`endif
    if (tick) begin
      if (!fire)
        armed_n = 1'b1;
      case (state)
        IDLE: begin
          if (fire && armed) begin
            state_n = FLY;
            bx_n    = launch_x[9:0];
            by_n    = ShooterY;
            on_n    = 1'b1;
            armed_n = 1'b0;
          end
        end
        FLY: begin
          if (contact || off_edge) begin
            on_n = 1'b0;
            if (contact) begin
              hit_n = 1'b1;
              if (hit_count != 4'd15)
                hc_n = hit_count + 4'd1;
            end
`ifdef BULLET_COOLDOWN_EN
            state_n = COOLDOWN;
            cnt_n   = 8'(COOLDOWN_FRAMES - 1);
`else
            state_n = IDLE;
`endif
          end else begin
            bx_n = next_x[9:0];
          end
        end
`ifdef BULLET_COOLDOWN_EN
        COOLDOWN: begin
          if (cnt == 8'd0)
            state_n = IDLE;
          else
            cnt_n = cnt - 8'd1;
        end
`endif
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync_s1   <= 1'b0;
      sync_s2   <= 1'b0;
      armed     <= 1'b1;
      BulletX   <= 10'd0;
      BulletY   <= 10'd0;
      on_q      <= 1'b0;
      hit       <= 1'b0;
      hit_count <= 4'd0;
`ifdef BULLET_COOLDOWN_EN
      cnt       <= 8'd0;
`endif
    end else begin
      sync_s1   <= frame_clk;
      sync_s2   <= sync_s1;
      armed     <= armed_n;
      BulletX   <= bx_n;
      BulletY   <= by_n;
      on_q      <= on_n;
      hit       <= hit_n;
      hit_count <= hc_n;
`ifdef BULLET_COOLDOWN_EN
      cnt       <= cnt_n;
`endif
    end
  end

endmodule

// File: tb/tb_bullet_controller.sv
// Directed bench for bullet_controller (DIR=1): reset, launch/move, edge retire, contact, saturation, hold-fire, refire.
module tb_bullet_controller;

   logic       Clk = 1'b0;
   logic       Reset_n = 1'b0;
   logic       frame_clk = 1'b0;
   logic       fire = 1'b0;
   logic [9:0] ShooterX = 10'd100, ShooterY = 10'd200;
   logic [9:0] TargetX = 10'd500, TargetY = 10'd50;
   logic [9:0] BulletX, BulletY, bullet_on;
   logic       hit;
   logic [3:0] hit_count;

   int checks = 0;
   int failures = 0;
   int hit_cycles = 0;
   int n;
   logic [3:0] exp_hc;

   bullet_controller dut (
      .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .fire(fire),
      .ShooterX(ShooterX), .ShooterY(ShooterY), .TargetX(TargetX), .TargetY(TargetY),
      .BulletX(BulletX), .BulletY(BulletY), .bullet_on(bullet_on),
      .hit(hit), .hit_count(hit_count)
   );

   always #5 Clk = ~Clk;

   // One frame_clk pulse; counts the Clk cycles in which hit is high.
   task automatic frame_tick();
      hit_cycles = 0;
      @(negedge Clk);
      frame_clk = 1'b1;
      repeat (4) begin
         @(negedge Clk);
         if (hit) hit_cycles++;
      end
      frame_clk = 1'b0;
      repeat (2) @(negedge Clk);
   endtask

`ifdef BULLET_COOLDOWN_EN
   localparam int CD_TICKS = 30;
`else
   localparam int CD_TICKS = 0;
`endif

   // Re-arm, launch at 108 and fly into the target at 150 (contact evaluated at 144).
   task automatic launch_and_hit();
      fire = 1'b0;
      frame_tick();
      for (int i = 1; i < CD_TICKS; i++) frame_tick();
      fire = 1'b1;
      frame_tick();
      repeat (10) frame_tick();
   endtask

   initial begin
      repeat (3) @(negedge Clk);
      checks++;
      if (BulletX !== 10'd0) begin failures++; $display("FAIL rst_bx observed=%0d expected=%0d", BulletX, 0); end
      checks++;
      if (BulletY !== 10'd0) begin failures++; $display("FAIL rst_by observed=%0d expected=%0d", BulletY, 0); end
      checks++;
      if (bullet_on !== 10'd0) begin failures++; $display("FAIL rst_on observed=%0d expected=%0d", bullet_on, 0); end
      checks++;
      if (hit !== 1'b0) begin failures++; $display("FAIL rst_hit observed=%0d expected=%0d", hit, 0); end
      checks++;
      if (hit_count !== 4'd0) begin failures++; $display("FAIL rst_hc observed=%0d expected=%0d", hit_count, 0); end
      Reset_n = 1'b1;
      repeat (2) @(negedge Clk);

      fire = 1'b1;
      frame_tick();
      checks++;
      if (BulletX !== 10'd108) begin failures++; $display("FAIL launch_bx observed=%0d expected=%0d", BulletX, 108); end
      checks++;
      if (BulletY !== 10'd200) begin failures++; $display("FAIL launch_by observed=%0d expected=%0d", BulletY, 200); end
      checks++;
      if (bullet_on !== 10'd1) begin failures++; $display("FAIL launch_on observed=%0d expected=%0d", bullet_on, 1); end
      frame_tick();
      checks++;
      if (BulletX !== 10'd112) begin failures++; $display("FAIL move1_bx observed=%0d expected=%0d", BulletX, 112); end
      frame_tick();
      checks++;
      if (BulletX !== 10'd116) begin failures++; $display("FAIL move2_bx observed=%0d expected=%0d", BulletX, 116); end
      checks++;
      if (BulletY !== 10'd200) begin failures++; $display("FAIL move2_by observed=%0d expected=%0d", BulletY, 200); end

      #2 Reset_n = 1'b0;
      #1;
      checks++;
      if (BulletX !== 10'd0) begin failures++; $display("FAIL midrst_bx observed=%0d expected=%0d", BulletX, 0); end
      checks++;
      if (BulletY !== 10'd0) begin failures++; $display("FAIL midrst_by observed=%0d expected=%0d", BulletY, 0); end
      checks++;
      if (bullet_on !== 10'd0) begin failures++; $display("FAIL midrst_on observed=%0d expected=%0d", bullet_on, 0); end
      @(negedge Clk);
      Reset_n = 1'b1;
      @(negedge Clk);
      frame_tick();
      checks++;
      if (BulletX !== 10'd108) begin failures++; $display("FAIL relaunch_bx observed=%0d expected=%0d", BulletX, 108); end
      checks++;
      if (bullet_on !== 10'd1) begin failures++; $display("FAIL relaunch_on observed=%0d expected=%0d", bullet_on, 1); end

      n = 0;
      while (BulletX != 10'd636 && n < 200) begin
         frame_tick();
         n++;
      end
      checks++;
      if (n !== 132) begin failures++; $display("FAIL edge_reach_ticks observed=%0d expected=%0d", n, 132); end
      checks++;
      if (bullet_on !== 10'd1) begin failures++; $display("FAIL edge_pre_on observed=%0d expected=%0d", bullet_on, 1); end
      frame_tick();
      checks++;
      if (bullet_on !== 10'd0) begin failures++; $display("FAIL edge_on observed=%0d expected=%0d", bullet_on, 0); end
      checks++;
      if (BulletX !== 10'd636) begin failures++; $display("FAIL edge_bx_hold observed=%0d expected=%0d", BulletX, 636); end
      checks++;
      if (hit_cycles !== 0) begin failures++; $display("FAIL edge_hit observed=%0d expected=%0d", hit_cycles, 0); end
      checks++;
      if (hit_count !== 4'd0) begin failures++; $display("FAIL edge_hc observed=%0d expected=%0d", hit_count, 0); end

      repeat (CD_TICKS + 3) frame_tick();
      checks++;
      if (bullet_on !== 10'd0) begin failures++; $display("FAIL holdfire_on observed=%0d expected=%0d", bullet_on, 0); end
      checks++;
      if (BulletX !== 10'd636) begin failures++; $display("FAIL holdfire_bx observed=%0d expected=%0d", BulletX, 636); end

      fire = 1'b0;
      frame_tick();
      fire = 1'b1;
      frame_tick();
      checks++;
      if (bullet_on !== 10'd1) begin failures++; $display("FAIL rearm_on observed=%0d expected=%0d", bullet_on, 1); end
      checks++;
      if (BulletX !== 10'd108) begin failures++; $display("FAIL rearm_bx observed=%0d expected=%0d", BulletX, 108); end

      TargetX = 10'd150;
      TargetY = 10'd200;
      repeat (8) frame_tick();
      checks++;
      if (BulletX !== 10'd140) begin failures++; $display("FAIL contact_140_bx observed=%0d expected=%0d", BulletX, 140); end
      frame_tick();
      checks++;
      if (BulletX !== 10'd144) begin failures++; $display("FAIL contact_144_bx observed=%0d expected=%0d", BulletX, 144); end
      checks++;
      if (bullet_on !== 10'd1) begin failures++; $display("FAIL contact_144_on observed=%0d expected=%0d", bullet_on, 1); end
      checks++;
      if (hit_cycles !== 0) begin failures++; $display("FAIL contact_140_nohit observed=%0d expected=%0d", hit_cycles, 0); end
      checks++;
      if (hit_count !== 4'd0) begin failures++; $display("FAIL contact_140_hc observed=%0d expected=%0d", hit_count, 0); end
      frame_tick();
      checks++;
      if (hit_cycles !== 1) begin failures++; $display("FAIL contact_hit_width observed=%0d expected=%0d", hit_cycles, 1); end
      checks++;
      if (bullet_on !== 10'd0) begin failures++; $display("FAIL contact_on observed=%0d expected=%0d", bullet_on, 0); end
      checks++;
      if (hit_count !== 4'd1) begin failures++; $display("FAIL contact_hc observed=%0d expected=%0d", hit_count, 1); end
      checks++;
      if (BulletX !== 10'd144) begin failures++; $display("FAIL contact_bx_hold observed=%0d expected=%0d", BulletX, 144); end

      for (int k = 2; k <= 16; k++) begin
         launch_and_hit();
         exp_hc = 4'((k > 15) ? 15 : k);
         checks++;
         if (hit_cycles !== 1) begin failures++; $display("FAIL sat_hit_width observed=%0d expected=%0d", hit_cycles, 1); end
         checks++;
         if (hit_count !== exp_hc) begin failures++; $display("FAIL sat_hc observed=%0d expected=%0d", hit_count, exp_hc); end
      end
      checks++;
      if (hit_count !== 4'd15) begin failures++; $display("FAIL sat_final_hc observed=%0d expected=%0d", hit_count, 15); end

      fire = 1'b0;
      frame_tick();
      fire = 1'b1;
      frame_tick();
`ifdef BULLET_COOLDOWN_EN
      checks++;
      if (bullet_on !== 10'd0) begin failures++; $display("FAIL cooldown_tick2_on observed=%0d expected=%0d", bullet_on, 0); end
      repeat (28) frame_tick();
      checks++;
      if (bullet_on !== 10'd0) begin failures++; $display("FAIL cooldown_tick30_on observed=%0d expected=%0d", bullet_on, 0); end
      frame_tick();
      checks++;
      if (bullet_on !== 10'd1) begin failures++; $display("FAIL cooldown_tick31_on observed=%0d expected=%0d", bullet_on, 1); end
`else
      checks++;
      if (bullet_on !== 10'd1) begin failures++; $display("FAIL refire_on observed=%0d expected=%0d", bullet_on, 1); end
      checks++;
      if (BulletX !== 10'd108) begin failures++; $display("FAIL refire_bx observed=%0d expected=%0d", BulletX, 108); end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #3000000;
      failures++;
      $display("FAIL timeout observed=running expected=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

endmodule
